// File: rtl/ext_pkg.sv
// Shared types and constants for the immediate-extension pipeline.
package ext_pkg;

    typedef enum logic [1:0] {
        EXT_ZERO   = 2'd0,
        EXT_SIGN   = 2'd1,
        EXT_UPPER  = 2'd2,
        EXT_BRANCH = 2'd3
    } ext_op_t;

    localparam int unsigned EXT_FIFO_DEPTH = 2;

endpackage

// File: rtl/ext_core.sv
// Combinational immediate extender: (imm, op) -> (result, err).
// EXT_BRANCH_EN builds the branch-offset shifter; otherwise mode 3 flags an error.
module ext_core
    import ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm_i,
    input  logic [1:0]       op_i,
    output logic [OUT_W-1:0] result_o,
    output logic             err_o
);

    ext_op_t          op;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] upper;

    assign op    = ext_op_t'(op_i);
    assign zext  = {{(OUT_W-IN_W){1'b0}}, imm_i};
    assign sext  = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};
    assign upper = {imm_i, {(OUT_W-IN_W){1'b0}}};

    always_comb begin
        result_o = zext;
        err_o    = 1'b0;
        case (op)
            EXT_ZERO:  result_o = zext;
            EXT_SIGN:  result_o = sext;
            EXT_UPPER: result_o = upper;
`ifdef EXT_BRANCH_EN
            EXT_BRANCH: result_o = {sext[OUT_W-3:0], 2'b00};
`else
            EXT_BRANCH: begin
                result_o = zext;
                err_o    = 1'b1;
            end
`endif
            default: begin
                result_o = zext;
                err_o    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: valid/ready input, 2-entry result FIFO on the output.
// Optional feature macro: EXT_BRANCH_EN (enables mode 3 branch-offset extension).
module imm_ext_pipe
    import ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_op_err
);

    localparam int unsigned PTR_W = (EXT_FIFO_DEPTH > 1) ? $clog2(EXT_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(EXT_FIFO_DEPTH + 1);

    if (OUT_W < IN_W + 2) begin : g_bad_cfg
        $error("imm_ext_pipe: OUT_W must be at least IN_W+2");
    end

    logic [OUT_W-1:0] core_result;
    logic             core_err;

    ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm_i    (in_imm),
        .op_i     (in_op),
        .result_o (core_result),
        .err_o    (core_err)
    );

    logic [OUT_W-1:0] imm_q [EXT_FIFO_DEPTH];
    logic [TAG_W-1:0] tag_q [EXT_FIFO_DEPTH];
    logic             err_q [EXT_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    // Ready comes from the registered count only, so no combinational path from out_ready.
    assign in_ready  = (count_q < CNT_W'(EXT_FIFO_DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_imm    = imm_q[rd_ptr_q];
    assign out_tag    = tag_q[rd_ptr_q];
    assign out_op_err = err_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(EXT_FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(EXT_FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < EXT_FIFO_DEPTH; i++) begin
                imm_q[i] <= '0;
                tag_q[i] <= '0;
                err_q[i] <= 1'b0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                imm_q[wr_ptr_q] <= core_result;
                tag_q[wr_ptr_q] <= in_tag;
                err_q[wr_ptr_q] <= core_err;
            end
        end
    end

endmodule
